hex_debug_mux: RTL and testbench

Parametrised successor to the fixed six-digit switch-selected debug display mux. It selects one of NUM_CH debug words (CPU regs, address bus, ROM programmer address/data, ...) for the board seven-segment digits. Display modes are live, strobe-capture, freeze and auto-scroll for words wider than the display. Outputs are registered nibbles plus per-digit blank flags that feed the existing HexDriver instances.

---
 rtl/hex_debug_mux.sv | 182 ++++++++++++++++++
 tb/tb_hex_debug_mux.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hex_debug_mux.sv
`default_nettype none
// ============================================================================
//  Module   : hex_debug_mux
//  Purpose  : Selects one of NUM_CH debug words for the seven-segment digits.
//             Supports live, strobe-capture, freeze and auto-scroll display
//             modes with optional leading-zero blanking. Outputs are
//             registered nibbles plus per-digit blank flags for HexDriver.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module hex_debug_mux #(
    parameter int NUM_CH     = 8,
    parameter int CH_WIDTH   = 32,
    parameter int NUM_DIGITS = 6,
    parameter int SCROLL_DIV = 25000000,
    parameter int LZ_BLANK   = 0
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic [NUM_CH*CH_WIDTH-1:0]   ch_data,
    input  logic [$clog2(NUM_CH)-1:0]    sel,
    input  logic [1:0]                   mode,
    input  logic                         strobe,
    output logic [NUM_DIGITS*4-1:0]      hex_digits,
    output logic [NUM_DIGITS-1:0]        digit_blank,
    output logic                         cap_valid,
    output logic [7:0]                   cap_count
);

    localparam int c_ND        = CH_WIDTH / 4;
    localparam int c_SEL_W     = $clog2(NUM_CH);
    localparam int c_OFF_W     = $clog2(c_ND + 1);
    localparam int c_DIV_W     = $clog2(SCROLL_DIV);
    localparam bit c_SCROLL_EN = (c_ND > NUM_DIGITS);
    localparam int c_MAX_OFF   = c_SCROLL_EN ? (c_ND - NUM_DIGITS) : 0;

    localparam logic [1:0] c_MODE_LIVE    = 2'b00;
    localparam logic [1:0] c_MODE_CAPTURE = 2'b01;
    localparam logic [1:0] c_MODE_FREEZE  = 2'b10;
    localparam logic [1:0] c_MODE_SCROLL  = 2'b11;

    logic [CH_WIDTH-1:0]     r_src_word;
    logic                    r_oor;
    logic [CH_WIDTH-1:0]     r_cap_word;
    logic                    r_strobe_q;
    logic [c_SEL_W-1:0]      r_sel_q;
    logic [1:0]              r_mode_q;
    logic [c_OFF_W-1:0]      r_offset;
    logic [c_DIV_W-1:0]      r_div;

    logic [CH_WIDTH-1:0]     w_ch_word;
    logic                    w_sel_oor;
    logic                    w_rise;
    logic                    w_scroll_clear;
    logic [CH_WIDTH-1:0]     w_shifted;
    logic [NUM_DIGITS*4-1:0] w_digits;
    logic [NUM_DIGITS-1:0]   w_width_blank;
    logic [NUM_DIGITS-1:0]   w_lz_blank;
    logic [NUM_DIGITS-1:0]   w_blank_next;
    logic                    w_seen;

    // Channel mux; an out-of-range select reads as zero
    always_comb begin
        w_ch_word = '0;
        w_sel_oor = (int'(sel) >= NUM_CH);
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(sel) == k) begin
                w_ch_word = ch_data[k*CH_WIDTH +: CH_WIDTH];
            end
        end
    end

    assign w_rise = strobe & ~r_strobe_q;

    // A select change, leaving scroll, or entering scroll restarts the window
    assign w_scroll_clear = (mode != c_MODE_SCROLL) || (sel != r_sel_q) ||
                            (r_mode_q != c_MODE_SCROLL) || !c_SCROLL_EN;

    // Edge-detect history and change-detect history
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_strobe_q <= 1'b0;
            r_sel_q    <= '0;
            r_mode_q   <= c_MODE_LIVE;
        end else begin
            r_strobe_q <= strobe;
            r_sel_q    <= sel;
            r_mode_q   <= mode;
        end
    end

    // Capture on strobe rise unless frozen; count saturates at 255
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_cap_word <= '0;
            cap_valid  <= 1'b0;
            cap_count  <= 8'd0;
        end else if (w_rise && (mode != c_MODE_FREEZE)) begin
            r_cap_word <= w_ch_word;
            cap_valid  <= 1'b1;
            if (cap_count != 8'hFF) begin
                cap_count <= cap_count + 8'd1;
            end
        end
    end

    // Stage 1: choose the displayed source word for the current mode
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_src_word <= '0;
            r_oor      <= 1'b0;
        end else begin
            case (mode)
                c_MODE_LIVE, c_MODE_SCROLL: begin
                    r_src_word <= w_ch_word;
                    r_oor      <= w_sel_oor;
                end
                c_MODE_CAPTURE: begin
                    r_src_word <= w_sel_oor ? '0 : r_cap_word;
                    r_oor      <= w_sel_oor;
                end
                default: begin
                    r_src_word <= r_src_word;
                    r_oor      <= r_oor;
                end
            endcase
        end
    end

    // Scroll divider and window offset, wrapping at the last full window
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_offset <= '0;
            r_div    <= '0;
        end else if (w_scroll_clear) begin
            r_offset <= '0;
            r_div    <= '0;
        end else if (r_div == c_DIV_W'(SCROLL_DIV - 1)) begin
            r_div    <= '0;
            r_offset <= (r_offset == c_OFF_W'(c_MAX_OFF)) ? '0 : r_offset + 1'b1;
        end else begin
            r_div    <= r_div + 1'b1;
        end
    end

    assign w_shifted = r_src_word >> {r_offset, 2'b00};

    // Digits beyond the channel width are dark zeros
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        if (i < c_ND) begin : g_shown
            assign w_digits[4*i +: 4] = w_shifted[4*i +: 4];
            assign w_width_blank[i]   = 1'b0;
        end else begin : g_unused
            assign w_digits[4*i +: 4] = 4'h0;
            assign w_width_blank[i]   = 1'b1;
        end
    end

    // Leading-zero mask: dark above the highest non-zero digit, digit 0 always lit
    always_comb begin
        w_lz_blank = '0;
        w_seen     = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_seen        = w_seen | (w_digits[4*i +: 4] != 4'h0);
            w_lz_blank[i] = ~w_seen;
        end
    end

    assign w_blank_next = w_width_blank | ((LZ_BLANK != 0) ? w_lz_blank : '0);

    // Stage 2: registered digits and blank flags; out-of-range darkens all
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            hex_digits  <= '0;
            digit_blank <= '1;
        end else begin
            hex_digits  <= w_digits;
            digit_blank <= r_oor ? '1 : w_blank_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hex_debug_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hex_debug_mux
//  Purpose  : Directed self-checking bench for hex_debug_mux using three
//             instances (16-bit live, 32-bit capture/scroll, 6-channel LZB).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hex_debug_mux;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A: 8 x 16-bit, live latency
    logic [127:0] a_ch;
    logic [2:0]   a_sel;
    logic [1:0]   a_mode;
    logic         a_strobe;
    logic [23:0]  a_hex;
    logic [5:0]   a_blank;
    logic         a_valid;
    logic [7:0]   a_count;

    // Instance B: 8 x 32-bit, capture / freeze / scroll
    logic [255:0] b_ch;
    logic [2:0]   b_sel;
    logic [1:0]   b_mode;
    logic         b_strobe;
    logic [23:0]  b_hex;
    logic [5:0]   b_blank;
    logic         b_valid;
    logic [7:0]   b_count;

    // Instance C: 6 x 32-bit, leading-zero blanking, out-of-range select
    logic [191:0] c_ch;
    logic [2:0]   c_sel;
    logic [1:0]   c_mode;
    logic         c_strobe;
    logic [23:0]  c_hex;
    logic [5:0]   c_blank;
    logic         c_valid;
    logic [7:0]   c_count;

    hex_debug_mux #(.NUM_CH(8), .CH_WIDTH(16), .NUM_DIGITS(6), .SCROLL_DIV(4), .LZ_BLANK(0)) u_a (
        .Clk(Clk), .Reset_n(Reset_n), .ch_data(a_ch), .sel(a_sel), .mode(a_mode),
        .strobe(a_strobe), .hex_digits(a_hex), .digit_blank(a_blank),
        .cap_valid(a_valid), .cap_count(a_count));

    hex_debug_mux #(.NUM_CH(8), .CH_WIDTH(32), .NUM_DIGITS(6), .SCROLL_DIV(4), .LZ_BLANK(0)) u_b (
        .Clk(Clk), .Reset_n(Reset_n), .ch_data(b_ch), .sel(b_sel), .mode(b_mode),
        .strobe(b_strobe), .hex_digits(b_hex), .digit_blank(b_blank),
        .cap_valid(b_valid), .cap_count(b_count));

    hex_debug_mux #(.NUM_CH(6), .CH_WIDTH(32), .NUM_DIGITS(6), .SCROLL_DIV(4), .LZ_BLANK(1)) u_c (
        .Clk(Clk), .Reset_n(Reset_n), .ch_data(c_ch), .sel(c_sel), .mode(c_mode),
        .strobe(c_strobe), .hex_digits(c_hex), .digit_blank(c_blank),
        .cap_valid(c_valid), .cap_count(c_count));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    initial begin
        a_ch = '0; a_sel = '0; a_mode = 2'b00; a_strobe = 1'b0;
        b_ch = '0; b_sel = '0; b_mode = 2'b00; b_strobe = 1'b0;
        c_ch = '0; c_sel = '0; c_mode = 2'b00; c_strobe = 1'b0;
        Reset_n = 1'b0;
        tick(3);

        check("rst_hex",   b_hex,   24'h000000);
        check("rst_blank", b_blank, 6'h3F);
        check("rst_valid", b_valid, 1'b0);
        check("rst_count", b_count, 8'd0);
        check("rst_blank_a", a_blank, 6'h3F);
        Reset_n = 1'b1;

        // Live latency on the 16-bit instance
        a_ch[3*16 +: 16] = 16'hBEEF;
        a_sel = 3'd3;
        tick(1);
        check("live_lat1", a_hex, 24'h000000);
        tick(1);
        check("live_lat2",   a_hex,   24'h00BEEF);
        check("live_blank",  a_blank, 6'b110000);
        a_ch[0 +: 16] = 16'hA5C3;
        a_sel = 3'd0;
        tick(2);
        check("live_sel0", a_hex, 24'h00A5C3);

        // Capture
        b_mode = 2'b01;
        b_ch[2*32 +: 32] = 32'h12345678;
        b_sel = 3'd2;
        tick(2);
        check("cap_empty", b_hex, 24'h000000);
        b_strobe = 1'b1;
        tick(5);
        b_strobe = 1'b0;
        check("cap_count1", b_count, 8'd1);
        check("cap_valid",  b_valid, 1'b1);
        check("cap_hex1",   b_hex,   24'h345678);
        b_ch[2*32 +: 32] = 32'hFFFFFFFF;
        tick(3);
        check("cap_hold", b_hex, 24'h345678);
        b_strobe = 1'b1;
        tick(1);
        b_strobe = 1'b0;
        tick(2);
        check("cap_hex2",   b_hex,   24'hFFFFFF);
        check("cap_count2", b_count, 8'd2);

        // Freeze
        b_mode = 2'b10;
        tick(2);
        b_strobe = 1'b1;
        tick(1);
        b_strobe = 1'b0;
        tick(1);
        check("frz_count", b_count, 8'd2);
        b_ch[2*32 +: 32] = 32'h00000000;
        tick(2);
        check("frz_hex_a", b_hex, 24'hFFFFFF);
        b_ch[2*32 +: 32] = 32'h55555555;
        tick(2);
        check("frz_hex_b", b_hex, 24'hFFFFFF);

        // Saturation
        b_mode = 2'b01;
        for (int i = 0; i < 300; i++) begin
            b_strobe = 1'b1;
            tick(1);
            b_strobe = 1'b0;
            tick(1);
        end
        check("sat_count", b_count, 8'd255);

        // Scroll
        b_ch[5*32 +: 32] = 32'h89ABCDEF;
        b_ch[6*32 +: 32] = 32'h89ABCDEF;
        b_sel = 3'd5;
        b_mode = 2'b11;
        tick(2);
        check("scr_off0",      b_hex, 24'hABCDEF);
        tick(3);
        check("scr_off0_end",  b_hex, 24'hABCDEF);
        tick(1);
        check("scr_off1",      b_hex, 24'h9ABCDE);
        tick(4);
        check("scr_off2",      b_hex, 24'h89ABCD);
        tick(4);
        check("scr_wrap",      b_hex, 24'hABCDEF);
        tick(5);
        check("scr_pre_sel",   b_hex, 24'h9ABCDE);
        b_sel = 3'd6;
        tick(2);
        check("scr_sel_clear", b_hex, 24'hABCDEF);
        tick(3);
        check("scr_div_clear", b_hex, 24'hABCDEF);
        tick(1);
        check("scr_after_clr", b_hex, 24'h9ABCDE);

        // Reset mid-scroll
        Reset_n = 1'b0;
        tick(1);
        check("mid_rst_hex",   b_hex,   24'h000000);
        check("mid_rst_blank", b_blank, 6'h3F);
        check("mid_rst_valid", b_valid, 1'b0);
        check("mid_rst_count", b_count, 8'd0);
        Reset_n = 1'b1;

        // Leading-zero blanking and out-of-range select
        c_ch[0 +: 32] = 32'h00000A00;
        c_sel = 3'd0;
        tick(2);
        check("lzb_hex",   c_hex,   24'h000A00);
        check("lzb_blank", c_blank, 6'b111000);
        c_ch[0 +: 32] = 32'h00000000;
        tick(2);
        check("lzb_zero",  c_blank, 6'b111110);
        c_ch[1*32 +: 32] = 32'h00ABCDEF;
        c_sel = 3'd1;
        tick(2);
        check("lzb_full_hex",   c_hex,   24'hABCDEF);
        check("lzb_full_blank", c_blank, 6'b000000);
        c_sel = 3'd7;
        tick(2);
        check("oor7_blank", c_blank, 6'h3F);
        check("oor7_hex",   c_hex,   24'h000000);
        c_sel = 3'd6;
        tick(2);
        check("oor6_blank", c_blank, 6'h3F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
